// File: rtl/demux3_stream_pkg.sv
// Shared datapath definitions for the 3:1 mux / 1:3 demux pair.
// The select encoding lives here so both ends of the pair decode one field identically.
package demux3_stream_pkg;

    localparam logic [1:0] SEL_CH0 = 2'b00;
    localparam logic [1:0] SEL_CH1 = 2'b01;
    localparam logic [1:0] SEL_CH2 = 2'b10;

    typedef enum logic [1:0] {
        CH0 = 2'd0,
        CH1 = 2'd1,
        CH2 = 2'd2
    } chan_t;

    // Code 11 aliases channel 2, matching the mux.
    function automatic chan_t decode_sel(input logic [1:0] sel);
        case (sel)
            SEL_CH0: return CH0;
            SEL_CH1: return CH1;
            default: return CH2;
        endcase
    endfunction

endpackage

// File: rtl/demux3_stream_slot1.sv
// Single-entry valid/ready buffer with a saturating accepted-transfer counter.
// A load and a drain on the same edge keep the slot full, giving one word per cycle.
module stream_slot1 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             cnt_clr,
    input  logic             ready,
    output logic             free,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0] state;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign valid = (state == FULL);
    assign free  = (state == EMPTY) || ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            data  <= '0;
        end else if (load) begin
            state <= FULL;
            data  <= load_data;
        end else if (state == FULL && ready) begin
            state <= EMPTY;
        end
    end

    // Clear beats a same-cycle accept; reset beats both.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/demux3_stream.sv
// 1:3 registered stream distributor: steers one valid/ready stream to one of three
// single-word channel buffers by a 2-bit select, counting accepts per channel.
module demux3_stream
    import demux3_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic             out_valid0,
    output logic             out_valid1,
    output logic             out_valid2,
    input  logic             out_ready0,
    input  logic             out_ready1,
    input  logic             out_ready2,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    input  logic             cnt_clr
);

    chan_t      target;
    logic [2:0] free;
    logic [2:0] load;
    logic       accept;

    // in_ready looks only at the selected channel, so a stalled channel never blocks others.
    assign target   = decode_sel(in_sel);
    assign in_ready = !reset && free[target];
    assign accept   = in_valid && in_ready;
    assign load     = accept ? (3'b001 << target) : 3'b000;

    stream_slot1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
        .clk(clk), .reset(reset), .load(load[0]), .load_data(in_data), .cnt_clr(cnt_clr),
        .ready(out_ready0), .free(free[0]), .data(out_data0), .valid(out_valid0), .cnt(cnt0)
    );

    stream_slot1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
        .clk(clk), .reset(reset), .load(load[1]), .load_data(in_data), .cnt_clr(cnt_clr),
        .ready(out_ready1), .free(free[1]), .data(out_data1), .valid(out_valid1), .cnt(cnt1)
    );

    stream_slot1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot2 (
        .clk(clk), .reset(reset), .load(load[2]), .load_data(in_data), .cnt_clr(cnt_clr),
        .ready(out_ready2), .free(free[2]), .data(out_data2), .valid(out_valid2), .cnt(cnt2)
    );

endmodule

// File: tb/tb_demux3_stream.sv
// Randomised and directed bench for demux3_stream (CNT_W=2 so saturation is reached often),
// checked every cycle against a channel-level behavioural model.
module tb_demux3_stream;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic             cnt_clr;
    logic [2:0]       ordy;
    logic [2:0]       ovld;
    logic [WIDTH-1:0] odata [3];
    logic [CNT_W-1:0] ocnt  [3];

    always #5 clk = ~clk;

    demux3_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out_data0(odata[0]), .out_data1(odata[1]), .out_data2(odata[2]),
        .out_valid0(ovld[0]), .out_valid1(ovld[1]), .out_valid2(ovld[2]),
        .out_ready0(ordy[0]), .out_ready1(ordy[1]), .out_ready2(ordy[2]),
        .cnt0(ocnt[0]), .cnt1(ocnt[1]), .cnt2(ocnt[2]),
        .cnt_clr(cnt_clr)
    );

    // Model: what each channel holds and how many words it has accepted.
    bit         m_full [3];
    int         m_word [3];
    int         m_count[3];
    bit         last_acc;
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dest(input logic [1:0] s);
        if (s == 2'b00) return 0;
        if (s == 2'b01) return 1;
        return 2;
    endfunction

    // Compare at negedge, then advance the model across the next rising edge.
    task automatic cycle();
        int  t;
        bit  rdy;
        @(negedge clk);
        t   = dest(in_sel);
        rdy = !reset && (!m_full[t] || ordy[t]);
        chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("out_valid%0d", i), {31'b0, ovld[i]}, {31'b0, m_full[i]});
            chk($sformatf("out_data%0d", i), {24'b0, odata[i]}, m_word[i]);
            chk($sformatf("cnt%0d", i), {30'b0, ocnt[i]}, m_count[i]);
        end
        last_acc = in_valid && rdy;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_full[i] = 0; m_word[i] = 0; m_count[i] = 0;
            end else begin
                if (last_acc && t == i) begin
                    m_full[i] = 1; m_word[i] = int'(in_data);
                end else if (ordy[i]) begin
                    m_full[i] = 0;
                end
                if (cnt_clr) m_count[i] = 0;
                else if (last_acc && t == i && m_count[i] < CMAX) m_count[i]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] s, input logic [7:0] d);
        in_sel = s; in_data = d; in_valid = 1'b1;
    endtask

    initial begin
        reset = 1'b1; in_data = '0; in_sel = 2'b00; in_valid = 1'b0; cnt_clr = 1'b0; ordy = 3'b000;
        for (int i = 0; i < 3; i++) begin m_full[i] = 0; m_word[i] = 0; m_count[i] = 0; end
        @(posedge clk); @(posedge clk); #1;
        cycle();
        reset = 1'b0;

        // Idle after reset: every select is ready.
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1 chk("idle_ready", {31'b0, in_ready}, 32'd1);
        end
        chk("idle_valid", {29'b0, ovld}, 32'd0);
        cycle();

        // Single word to ch1.
        ordy = 3'b010;
        send(2'b01, 8'hA5);
        cycle();
        in_valid = 1'b0;
        chk("a5_valid", {29'b0, ovld}, 32'b010);
        chk("a5_data", {24'b0, odata[1]}, 32'hA5);
        chk("a5_cnt", {30'b0, ocnt[1]}, 32'd1);
        ordy = 3'b111;
        cycle();

        // Ch2 stalled, aliased select held off, then same-edge drain and fill.
        ordy = 3'b000;
        send(2'b10, 8'h11);
        cycle();
        send(2'b11, 8'h22);
        #1 chk("alias_block", {31'b0, in_ready}, 32'd0);
        cycle();
        chk("ch2_hold", {24'b0, odata[2]}, 32'h11);
        ordy[2] = 1'b1;
        cycle();
        chk("ch2_refill", {24'b0, odata[2]}, 32'h22);
        chk("ch2_full", {31'b0, ovld[2]}, 32'd1);
        chk("ch2_cnt", {30'b0, ocnt[2]}, 32'd2);
        in_valid = 1'b0; ordy = 3'b111;
        cycle();

        // Stalled ch0 does not block ch1.
        ordy = 3'b000;
        send(2'b00, 8'h33);
        cycle();
        send(2'b01, 8'h44);
        #1 chk("bypass_ready", {31'b0, in_ready}, 32'd1);
        cycle();
        chk("ch0_kept", {24'b0, odata[0]}, 32'h33);
        chk("ch1_loaded", {24'b0, odata[1]}, 32'h44);

        // Saturation at 3 and clear winning over a same-cycle accept.
        ordy = 3'b111;
        for (int k = 0; k < 5; k++) begin
            send(2'b00, 8'(8'h50 + k));
            cycle();
        end
        chk("cnt0_sat", {30'b0, ocnt[0]}, 32'd3);
        cnt_clr = 1'b1;
        send(2'b00, 8'h77);
        cycle();
        cnt_clr = 1'b0;
        chk("clr_wins", {30'b0, ocnt[0]}, 32'd0);
        chk("clr_data", {24'b0, odata[0]}, 32'h77);

        // Reset with all channels full, then a normal transfer.
        ordy = 3'b000;
        for (int k = 0; k < 3; k++) begin
            send(2'(k), 8'(8'h80 + k));
            cycle();
        end
        chk("all_full", {29'b0, ovld}, 32'b111);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rst_valid", {29'b0, ovld}, 32'd0);
        chk("rst_cnt2", {30'b0, ocnt[2]}, 32'd0);
        chk("rst_data1", {24'b0, odata[1]}, 32'd0);
        send(2'b01, 8'h5A);
        cycle();
        chk("post_rst", {24'b0, odata[1]}, 32'h5A);
        chk("post_rst_cnt", {30'b0, ocnt[1]}, 32'd1);

        // Random traffic; the source holds a word until it is accepted.
        in_valid = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!(in_valid && !last_acc) || reset) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 2'($urandom_range(0, 3));
                in_data  = 8'($urandom);
            end
            ordy    = 3'($urandom);
            cnt_clr = ($urandom_range(0, 31) == 0);
            reset   = ($urandom_range(0, 79) == 0);
            cycle();
        end
        reset = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
